// File: rtl/painterengine_gpu_writer_scheduler_if.sv
// Signal bundle between the four requesters, the shared GPU DMA writer and the
// round-robin scheduler that sequences writer jobs.
interface painterengine_gpu_writer_scheduler_if;
  logic [3:0] i_wire_request;
  logic [3:0] o_wire_grant;
  logic [3:0] o_wire_done;
  logic [3:0] o_wire_error;
  logic [2:0] o_wire_error_type;
  logic       o_wire_busy;
  logic       o_wire_writer_resetn;
  logic [3:0] o_wire_writer_router;
  logic       i_wire_writer_done;
  logic       i_wire_writer_error;
  logic [2:0] i_wire_writer_error_type;

  modport slave (
    input  i_wire_request,
    output o_wire_grant,
    output o_wire_done,
    output o_wire_error,
    output o_wire_error_type,
    output o_wire_busy,
    output o_wire_writer_resetn,
    output o_wire_writer_router,
    input  i_wire_writer_done,
    input  i_wire_writer_error,
    input  i_wire_writer_error_type
  );

  modport master (
    output i_wire_request,
    input  o_wire_grant,
    input  o_wire_done,
    input  o_wire_error,
    input  o_wire_error_type,
    input  o_wire_busy,
    input  o_wire_writer_resetn,
    input  o_wire_writer_router,
    output i_wire_writer_done,
    output i_wire_writer_error,
    output i_wire_writer_error_type
  );
endinterface

// File: rtl/painterengine_gpu_writer_scheduler.sv
// Round-robin scheduler sharing one GPU DMA writer among four channels: arbitrate,
// release the writer from reset, wait for done/error/timeout, pulse the result.
module painterengine_gpu_writer_scheduler #(
  parameter logic [31:0] PARAM_TIMEOUT      = 32'd1000000,
  parameter int unsigned PARAM_RESET_CYCLES = 4
) (
  input logic i_wire_clock,
  input logic i_wire_resetn,
  painterengine_gpu_writer_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_FINISH,
    S_HOLD
  } state_e;

  // HOLD lasts PARAM_RESET_CYCLES-1 cycles; together with FINISH the writer
  // sees PARAM_RESET_CYCLES low cycles of reset after every job.
  localparam logic [7:0] HOLD_LAST = 8'(PARAM_RESET_CYCLES - 2);

  state_e      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  done_q, done_d;
  logic [3:0]  error_q, error_d;
  logic [2:0]  etype_q, etype_d;
  logic        busy_q, busy_d;
  logic        wrstn_q, wrstn_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [7:0]  hold_q, hold_d;

  logic        win_valid;
  logic [1:0]  win_idx;
  logic [1:0]  cand;

  // Scan last+1 .. last+4 (mod 4); the served channel comes last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_q + i[1:0];
      if (!win_valid && bus.i_wire_request[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    error_d = '0;
    etype_d = etype_q;
    wrstn_d = 1'b0;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    hold_d  = hold_q;

    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (win_valid) begin
          grant_d = 4'b0001 << win_idx;
          last_d  = win_idx;
          state_d = S_START;
        end
      end
      S_START: begin
        wrstn_d = 1'b1;
        tcnt_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wrstn_d = 1'b1;
        if (tcnt_q != '1) tcnt_d = tcnt_q + 32'd1;
        if (bus.i_wire_writer_error) begin
          error_d = grant_q;
          etype_d = bus.i_wire_writer_error_type;
          wrstn_d = 1'b0;
          state_d = S_FINISH;
        end else if (bus.i_wire_writer_done) begin
          done_d  = grant_q;
          wrstn_d = 1'b0;
          state_d = S_FINISH;
        end else if ((PARAM_TIMEOUT != 32'd0) && (tcnt_q == PARAM_TIMEOUT - 32'd1)) begin
          error_d = grant_q;
          etype_d = 3'b111;
          wrstn_d = 1'b0;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        grant_d = '0;
        hold_d  = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        grant_d = '0;
        if (hold_q == HOLD_LAST) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      error_q <= '0;
      etype_q <= '0;
      busy_q  <= 1'b0;
      wrstn_q <= 1'b0;
      last_q  <= 2'd3;
      tcnt_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      error_q <= error_d;
      etype_q <= etype_d;
      busy_q  <= busy_d;
      wrstn_q <= wrstn_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.o_wire_grant         = grant_q;
  assign bus.o_wire_writer_router = grant_q;
  assign bus.o_wire_done          = done_q;
  assign bus.o_wire_error         = error_q;
  assign bus.o_wire_error_type    = etype_q;
  assign bus.o_wire_busy          = busy_q;
  assign bus.o_wire_writer_resetn = wrstn_q;

endmodule

// File: tb/tb_painterengine_gpu_writer_scheduler.sv
// Directed bench for the writer scheduler: round-robin order, done/error/timeout
// completion, error-type hold, simultaneous done+error, and mid-job reset.
module tb_painterengine_gpu_writer_scheduler;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;
  logic [2:0] last_et;

  painterengine_gpu_writer_scheduler_if bus ();

  painterengine_gpu_writer_scheduler #(
    .PARAM_TIMEOUT      (32'd50),
    .PARAM_RESET_CYCLES (4)
  ) dut (
    .i_wire_clock  (clk),
    .i_wire_resetn (rstn),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 done, 1 error, 2 done+error together, 3 writer silent (timeout)
  task automatic do_job(input logic [3:0] exp_g, input int wait_n, input int mode,
                        input logic [2:0] et, input bit drop);
    logic [3:0] exp_d;
    logic [3:0] exp_e;
    tick();
    chk("grant", bus.o_wire_grant, exp_g);
    chk("router", bus.o_wire_writer_router, exp_g);
    chk("wrstn_start", bus.o_wire_writer_resetn, 0);
    chk("busy_start", bus.o_wire_busy, 1);
    tick();
    chk("wrstn_run", bus.o_wire_writer_resetn, 1);
    for (int i = 0; i < wait_n; i++) begin
      tick();
      chk("run_quiet", {bus.o_wire_done, bus.o_wire_error}, 0);
      chk("run_wrstn", bus.o_wire_writer_resetn, 1);
    end
    case (mode)
      0: bus.i_wire_writer_done = 1'b1;
      1: begin bus.i_wire_writer_error = 1'b1; bus.i_wire_writer_error_type = et; end
      2: begin
        bus.i_wire_writer_done = 1'b1;
        bus.i_wire_writer_error = 1'b1;
        bus.i_wire_writer_error_type = et;
      end
      default: ;
    endcase
    exp_d = (mode == 0) ? exp_g : 4'b0000;
    exp_e = (mode == 0) ? 4'b0000 : exp_g;
    if (mode == 3) last_et = 3'b111;
    else if (mode != 0) last_et = et;
    tick();
    chk("done_pulse", bus.o_wire_done, exp_d);
    chk("error_pulse", bus.o_wire_error, exp_e);
    chk("error_type", bus.o_wire_error_type, last_et);
    chk("finish_wrstn", bus.o_wire_writer_resetn, 0);
    chk("finish_grant", bus.o_wire_grant, exp_g);
    bus.i_wire_writer_done = 1'b0;
    bus.i_wire_writer_error = 1'b0;
    bus.i_wire_writer_error_type = 3'b000;
    if (drop) bus.i_wire_request = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pulses", {bus.o_wire_done, bus.o_wire_error}, 0);
      chk("hold_grant", bus.o_wire_grant, 0);
      chk("hold_wrstn", bus.o_wire_writer_resetn, 0);
      chk("hold_busy", bus.o_wire_busy, 1);
    end
    tick();
    chk("idle_busy", bus.o_wire_busy, 0);
    chk("idle_etype", bus.o_wire_error_type, last_et);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    last_et = 3'b000;
    rstn = 1'b0;
    bus.i_wire_request = 4'b0000;
    bus.i_wire_writer_done = 1'b0;
    bus.i_wire_writer_error = 1'b0;
    bus.i_wire_writer_error_type = 3'b000;
    tick();
    tick();
    chk("rst_grant", bus.o_wire_grant, 0);
    chk("rst_router", bus.o_wire_writer_router, 0);
    chk("rst_done", bus.o_wire_done, 0);
    chk("rst_error", bus.o_wire_error, 0);
    chk("rst_etype", bus.o_wire_error_type, 0);
    chk("rst_busy", bus.o_wire_busy, 0);
    chk("rst_wrstn", bus.o_wire_writer_resetn, 0);
    rstn = 1'b1;
    tick();
    chk("idle_no_req", bus.o_wire_busy, 0);

    // All four requesting: strict rotation starting at channel 0.
    bus.i_wire_request = 4'b1111;
    do_job(4'b0001, 2, 0, 3'b000, 0);
    do_job(4'b0010, 0, 0, 3'b000, 0);
    do_job(4'b0100, 1, 0, 3'b000, 0);
    do_job(4'b1000, 0, 0, 3'b000, 0);
    do_job(4'b0001, 0, 0, 3'b000, 1);

    // Channel 1 writer error with code 3.
    bus.i_wire_request = 4'b0010;
    do_job(4'b0010, 3, 1, 3'b011, 1);

    // Channel 2 done 20 cycles into RUN; error type from previous failure holds.
    bus.i_wire_request = 4'b0100;
    do_job(4'b0100, 19, 0, 3'b000, 1);

    // Channel 3 watchdog: 50 RUN cycles, code 7.
    bus.i_wire_request = 4'b1000;
    do_job(4'b1000, 49, 3, 3'b000, 1);

    // Channel 0 with done and error together: error wins.
    bus.i_wire_request = 4'b0001;
    do_job(4'b0001, 0, 2, 3'b101, 1);

    // Reset during a channel-2 job.
    bus.i_wire_request = 4'b0100;
    tick();
    chk("mid_grant", bus.o_wire_grant, 4'b0100);
    tick();
    tick();
    tick();
    chk("mid_run", bus.o_wire_writer_resetn, 1);
    rstn = 1'b0;
    #1;
    chk("arst_grant", bus.o_wire_grant, 0);
    chk("arst_wrstn", bus.o_wire_writer_resetn, 0);
    chk("arst_busy", bus.o_wire_busy, 0);
    bus.i_wire_writer_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_pulse", {bus.o_wire_done, bus.o_wire_error}, 0);
    end
    bus.i_wire_writer_done = 1'b0;
    bus.i_wire_request = 4'b1111;
    last_et = 3'b000;
    rstn = 1'b1;
    // Pointer restored to 3, so channel 0 wins over everyone.
    do_job(4'b0001, 0, 0, 3'b000, 1);
    bus.i_wire_request = 4'b0001;
    do_job(4'b0001, 4, 0, 3'b000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_writer_scheduler.md
Name: painterengine_gpu_writer_scheduler

Overview:
Round-robin scheduler that shares the single GPU DMA writer between four requesters: channel 0..3 (e.g. framebuffer flush, blitter, texture writeback, debug). The writer takes a one-hot router select, runs one job and then parks in a done/error state. This block sequences each job for it:
- arbitrates pending requests;
- drives the writer's router select and holds the writer in reset between jobs;
- waits for writer done/error, with a watchdog;
- returns a per-channel completion or error pulse.

Parameters:
PARAM_TIMEOUT, 32'd1000000, RUN-state watchdog limit in cycles; 0 disables the watchdog.
PARAM_RESET_CYCLES, 4, cycles the writer reset is held low after each job; legal range 2..255.

Ports:
i_wire_clock  in  1  clock
i_wire_resetn  in  1  asynchronous active-low reset
i_wire_request  in  4  per-channel level request; held until that channel's done/error pulse
o_wire_grant  out  4  one-hot channel currently owning the writer; 0 when idle
o_wire_done  out  4  one-cycle pulse on the owning channel at successful completion
o_wire_error  out  4  one-cycle pulse on the owning channel at failure
o_wire_error_type  out  3  error code of the last failed job; holds until the next failure
o_wire_busy  out  1  high in every state except IDLE
o_wire_writer_resetn  out  1  synchronous-output reset to the writer; low except in RUN
o_wire_writer_router  out  4  one-hot router select to the writer (equal to o_wire_grant)
i_wire_writer_done  in  1  writer completion level
i_wire_writer_error  in  1  writer error level
i_wire_writer_error_type  in  3  writer error code, valid while i_wire_writer_error=1

Behaviour:
- Reset: i_wire_resetn, asynchronous, active-low; clock i_wire_clock. All outputs are registered. Reset values:
  - state = IDLE; grant = router = 0; done = error = 0; error_type = 0; busy = 0; writer_resetn = 0.
  - Round-robin pointer last = 3, so channel 0 has first priority.
  - timeout counter = 0; hold counter = 0.
- States: IDLE, START, RUN, FINISH, HOLD.
- IDLE:
  - writer_resetn = 0, grant = 0.
  - If request != 0, select the first set bit scanning last+1, last+2, ... (mod 4).
  - Next cycle: grant and router = one-hot of the winner, last = winner, state = START.
  - Latency from request to grant is 1 cycle.
- START:
  - Exactly 1 cycle with the router stable and the writer still in reset.
  - Next: writer_resetn = 1, timeout counter = 0, state = RUN.
- RUN:
  - writer_resetn = 1; the timeout counter increments each cycle.
  - writer_error = 1: error[winner] pulses next cycle, error_type = i_wire_writer_error_type, go to FINISH.
  - Else writer_done = 1: done[winner] pulses next cycle, go to FINISH.
  - Else PARAM_TIMEOUT != 0 and counter == PARAM_TIMEOUT-1: error[winner] pulses, error_type = 3'b111, go to FINISH.
  - If error and done are both high in the same cycle, error wins.
  - Deassertion of the owning request during RUN is ignored; the job runs to completion.
  - Other channels' requests are not sampled.
- FINISH:
  - The pulse output is high for this 1 cycle only.
  - writer_resetn = 0; grant and router stay held.
  - hold counter = 0; state = HOLD.
- HOLD:
  - writer_resetn = 0 and grant = 0 for PARAM_RESET_CYCLES-1 further cycles, then IDLE.
  - Requesters must drop their request within 1 cycle of their pulse. A request still high on return to IDLE is treated as a new job.
- Arbitration fairness: after serving channel k, channel k has the lowest priority. With all four requesting, service order is 0,1,2,3,0,...
- Reset asserted mid-job: all state clears immediately. The writer is held in reset; no done/error pulse is issued for the aborted job.
- Counter widths: timeout counter 32 bits, saturating; hold counter 8 bits.

Test Plan:
- request=4'b0100; writer_done rises 20 cycles after writer_resetn rises -> grant=4'b0100 at +1 cycle, writer_resetn=1 at +2, done=4'b0100 for 1 cycle, busy drops after PARAM_RESET_CYCLES+1 cycles.
- request=4'b1111 held; each job completes -> grants are 0001, 0010, 0100, 1000, 0001 in order; exactly one done pulse per job.
- Channel 1 job; writer_error=1 with error_type=3'b011 -> error=4'b0010 pulse, error_type=3'b011 held; done stays 0.
- PARAM_TIMEOUT=50; writer never signals -> error pulse after 50 RUN cycles, error_type=3'b111, writer_resetn low for PARAM_RESET_CYCLES cycles.
- writer_done and writer_error both high in the same cycle -> only the error pulse is issued.
- Reset pulse during RUN -> grant=0, writer_resetn=0, busy=0 immediately; after release, request=4'b0001 is served normally with channel 0 first.
